// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the port-A loader state type.
package fb_pkg;

  localparam int unsigned FB_ADDR_W    = 19;
  localparam int unsigned FB_IMG_W     = 400;
  localparam int unsigned FB_IMG_H     = 400;
  localparam int unsigned FB_DEPTH     = FB_IMG_W * FB_IMG_H;
  localparam int unsigned FB_QUAD_STEP = 100;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    DONE
  } loader_state_t;

endpackage

// File: rtl/fb_addr_counter.sv
// Byte counter for the framebuffer loader: clear, increment, and a sticky flag
// raised once the LIMIT-th increment has been accepted.
module fb_addr_counter
  import fb_pkg::*;
#(
  parameter int unsigned W     = FB_ADDR_W,
  parameter int unsigned LIMIT = FB_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;

  // The flag is registered on the last increment so LIMIT == 2**W still works.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = tc_q;
    if (clr_i) begin
      cnt_d = '0;
      tc_d  = 1'b0;
    end else if (inc_i && !tc_q) begin
      cnt_d = cnt_q + W'(1);
      tc_d  = (cnt_q == W'(LIMIT - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc_q;

endmodule

// File: rtl/fb_port_a_loader.sv
// Streams bytes from a valid/ready source into framebuffer RAM port A.
// Define FB_READBACK_VERIFY_EN to read back and compare every byte after writing it.
module fb_port_a_loader
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W    = FB_ADDR_W,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = FB_DEPTH,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address_a,
  output logic [7:0]        data_a,
  output logic              wren_a,
  input  logic [7:0]        q_a,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] byte_count,
  output logic              error
);

  if (DEPTH == 0 || (longint'(BASE_ADDR) + longint'(DEPTH)) > (longint'(1) << ADDR_W)) begin : g_bad_range
    $error("fb_port_a_loader: image region does not fit in ADDR_W address bits");
  end

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] ptr;
  logic              last_seen;
  logic              cnt_clr, cnt_inc;
  logic              fire;
  logic              unused_rd;

  fb_addr_counter #(
    .W     (ADDR_W),
    .LIMIT (DEPTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cnt),
    .tc_o  (last_seen)
  );

  assign ptr = ADDR_W'(BASE_ADDR) + cnt;

`ifdef FB_READBACK_VERIFY_EN
  localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              chk_q, chk_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  // A pending write blocks the handshake until its readback has been checked.
  assign in_ready  = (state_q == LOAD) && !last_seen && !wren_q;
  assign error     = err_q;
  // err_addr_q is a debug probe only.
  assign unused_rd = ^err_addr_q;
`else
  assign in_ready  = (state_q == LOAD) && !last_seen;
  assign error     = 1'b0;
  assign unused_rd = ^{q_a, (RD_LAT != 0)};
`endif

  assign fire = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef FB_READBACK_VERIFY_EN
    wait_d     = wait_q;
    chk_d      = 1'b0;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    // q_a now reflects the address held through VERIFY.
    if (chk_q && (q_a != data_q)) begin
      err_d      = 1'b1;
      err_addr_d = addr_q;
    end
`endif
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = LOAD;
            cnt_clr = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
`ifdef FB_READBACK_VERIFY_EN
            err_d   = 1'b0;
`endif
          end
        end
        LOAD: begin
          if (fire) begin
            cnt_inc = 1'b1;
            wren_d  = 1'b1;
            addr_d  = ptr;
            data_d  = in_data;
`ifdef FB_READBACK_VERIFY_EN
          end else if (wren_q) begin
            state_d = VERIFY;
            wait_d  = '0;
`else
          end else if (last_seen) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
`ifdef FB_READBACK_VERIFY_EN
        VERIFY: begin
          if (wait_q == WAIT_W'(RD_LAT - 1)) begin
            chk_d = 1'b1;
            if (last_seen) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= ADDR_W'(BASE_ADDR);
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef FB_READBACK_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q     <= '0;
      chk_q      <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      wait_q     <= wait_d;
      chk_q      <= chk_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end
`endif

  assign address_a  = addr_q;
  assign data_a     = data_q;
  assign wren_a     = wren_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign byte_count = cnt;

endmodule

// File: tb/tb_fb_port_a_loader.sv
// Self-checking bench for fb_port_a_loader (DEPTH=16, BASE_ADDR=0x100) with a
// behavioural port-A RAM model; readback checks follow FB_READBACK_VERIFY_EN.
`timescale 1ns/1ps
module tb_fb_port_a_loader;
  localparam int ADDR_W = 19;
  localparam int BASE   = 'h100;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 2;
`ifdef FB_READBACK_VERIFY_EN
  localparam int SPACING  = 2 + RD_LAT;
  localparam int DONE_LAT = 1 + RD_LAT;
  localparam bit VERIFY   = 1'b1;
`else
  localparam int SPACING  = 1;
  localparam int DONE_LAT = 1;
  localparam bit VERIFY   = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] address_a;
  logic [7:0]        data_a;
  logic              wren_a;
  logic [7:0]        q_a = '0;
  logic              busy, done, error;
  logic [ADDR_W-1:0] byte_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  fb_port_a_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .q_a(q_a),
    .busy(busy), .done(done), .byte_count(byte_count), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Port-A RAM: address registered, then data registered (2-cycle read latency).
  logic [7:0] mem [0:1023];
  logic [9:0] rd_addr_p1 = '0;
  bit         corrupt = 1'b0;
  always @(posedge clk) begin
    if (wren_a)
      mem[address_a[9:0]] <= (corrupt && address_a == ADDR_W'(BASE + 3)) ? ~data_a : data_a;
    rd_addr_p1 <= address_a[9:0];
    q_a        <= mem[rd_addr_p1];
  end

  // Write log and transfer log.
  int                wc[$];
  logic [ADDR_W-1:0] wa[$];
  logic [7:0]        wd[$];
  logic              we[$];
  int                tq[$];
  logic [7:0]        pat [DEPTH];

  always @(negedge clk) begin
    if (rst_n && wren_a) begin
      wc.push_back(cyc);
      wa.push_back(address_a);
      wd.push_back(data_a);
      we.push_back(error);
    end
  end

  task automatic clear_log();
    wc.delete(); wa.delete(); wd.delete(); we.delete(); tq.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill_pat(input bit random);
    for (int i = 0; i < DEPTH; i++) pat[i] = random ? 8'($urandom) : 8'(i);
  endtask

  // Offers pat[] bytes; start pulses once at byte start_at, abort fires at byte abort_at.
  task automatic feed(input int n, input int valid_pct, input int start_at,
                      input int abort_at, output int sent, output bit timeout);
    int i = 0;
    int guard = 0;
    bit st_done = 1'b0;
    timeout = 1'b0;
    while (i < n) begin
      if (guard > 1000) begin timeout = 1'b1; break; end
      guard++;
      start = (i == start_at) && !st_done;
      if (start) st_done = 1'b1;
      abort = (i == abort_at);
      in_valid = abort || ($urandom_range(99) < valid_pct);
      in_data = pat[i];
      @(negedge clk);
      if (abort) begin @(posedge clk); #1; break; end
      if (in_valid && in_ready) begin tq.push_back(cyc); i++; end
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    sent = i;
  endtask

  task automatic wait_done(output int done_cyc);
    int k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    done_cyc = cyc;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (address_a !== ADDR_W'(BASE)) begin n_fail++; $display("FAIL reset_addr: got %0h expected %0h", address_a, BASE); end
    n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", data_a); end
    n_checks++; if ({wren_a, in_ready, busy, done, error} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: wren/rdy/busy/done/err=%b expected 00000", {wren_a, in_ready, busy, done, error}); end
    n_checks++; if (byte_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", byte_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (wren_a || in_ready || busy || done) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_quiet: %0d active cycles, expected 0", bad); end
  endtask

  task automatic test_full_load();
    int sent, done_cyc, err;
    bit to;
    fill_pat(1'b0);
    clear_log();
    pulse_start();
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    feed(DEPTH, 100, -1, -1, sent, to);
    n_checks++; if (to || sent != DEPTH) begin n_fail++; $display("FAIL full_feed: sent %0d expected %0d", sent, DEPTH); end
    wait_done(done_cyc);
    n_checks++; if (wa.size() != DEPTH) begin n_fail++; $display("FAIL full_nwrites: got %0d expected %0d", wa.size(), DEPTH); end
    err = 0;
    for (int i = 0; i < DEPTH && i < wa.size(); i++) begin
      if (wa[i] !== ADDR_W'(BASE + i) || wd[i] !== pat[i]) err++;
      if (i > 0 && wc[i] - wc[i-1] != SPACING) err++;
    end
    n_checks++; if (err != 0) begin n_fail++; $display("FAIL full_writes: %0d bad addr/data/spacing, expected 0", err); end
    if (wc.size() > 0) begin
      n_checks++; if (done_cyc != wc[wc.size()-1] + DONE_LAT) begin n_fail++; $display("FAIL full_done_lat: done at +%0d expected +%0d", done_cyc - wc[wc.size()-1], DONE_LAT); end
    end
    n_checks++; if (byte_count !== ADDR_W'(DEPTH)) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", byte_count, DEPTH); end
    repeat (5) @(negedge clk);
    n_checks++; if ({done, busy, in_ready} !== 3'b100 || wa.size() != DEPTH) begin n_fail++; $display("FAIL full_hold: done/busy/rdy=%b writes=%0d expected 100 and %0d", {done, busy, in_ready}, wa.size(), DEPTH); end
    @(posedge clk); #1;
  endtask

  task automatic test_restart();
    int sent, done_cyc;
    bit to;
    fill_pat(1'b1);
    clear_log();
    pulse_start();
    @(negedge clk);
    n_checks++; if ({done, busy} !== 2'b01 || byte_count !== '0) begin n_fail++; $display("FAIL restart_clear: done/busy=%b count=%0d expected 01 and 0", {done, busy}, byte_count); end
    @(posedge clk); #1;
    feed(DEPTH, 100, -1, -1, sent, to);
    wait_done(done_cyc);
    n_checks++; if (wa.size() == 0 || wa[0] !== ADDR_W'(BASE) || wd[0] !== pat[0]) begin n_fail++; $display("FAIL restart_first: first write not at %0h with %0h", BASE, pat[0]); end
    n_checks++; if (wa.size() != DEPTH || done !== 1'b1) begin n_fail++; $display("FAIL restart_done: writes=%0d done=%b expected %0d and 1", wa.size(), done, DEPTH); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int sent, done_cyc, err;
    bit to;
    for (int rep = 0; rep < 2; rep++) begin
      fill_pat(1'b1);
      clear_log();
      pulse_start();
      feed(DEPTH, 40, -1, -1, sent, to);
      wait_done(done_cyc);
      n_checks++; if (to || wa.size() != DEPTH || tq.size() != DEPTH) begin n_fail++; $display("FAIL bp_count: writes=%0d transfers=%0d expected %0d", wa.size(), tq.size(), DEPTH); end
      err = 0;
      for (int i = 0; i < DEPTH && i < wa.size() && i < tq.size(); i++)
        if (wa[i] !== ADDR_W'(BASE + i) || wd[i] !== pat[i] || wc[i] != tq[i] + 1) err++;
      n_checks++; if (err != 0) begin n_fail++; $display("FAIL bp_writes: %0d writes not matching their transfer, expected 0", err); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_abort();
    int sent, err;
    bit to;
    fill_pat(1'b1);
    clear_log();
    pulse_start();
    feed(DEPTH, 70, 5, 8, sent, to);
    @(negedge clk);
    n_checks++; if ({busy, done, in_ready, wren_a} !== 4'b0000) begin n_fail++; $display("FAIL abort_idle: busy/done/rdy/wren=%b expected 0000", {busy, done, in_ready, wren_a}); end
    repeat (10) @(negedge clk);
    n_checks++; if (wa.size() != 8) begin n_fail++; $display("FAIL abort_nwrites: got %0d expected 8", wa.size()); end
    err = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== ADDR_W'(BASE + i) || wd[i] !== pat[i]) err++;
    n_checks++; if (err != 0) begin n_fail++; $display("FAIL abort_writes: %0d bad writes, expected 0", err); end
    n_checks++; if (byte_count !== ADDR_W'(8)) begin n_fail++; $display("FAIL abort_count: got %0d expected 8", byte_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_readback();
    int sent, done_cyc;
    bit to;
    fill_pat(1'b1);
    clear_log();
    corrupt = 1'b1;
    pulse_start();
    feed(DEPTH, 100, -1, -1, sent, to);
    wait_done(done_cyc);
    n_checks++; if (we.size() < 5 || we[3] !== 1'b0 || we[4] !== VERIFY) begin n_fail++; $display("FAIL rb_err_timing: error not rising after byte 3 check (expected %b)", VERIFY); end
    n_checks++; if (done !== 1'b1 || error !== VERIFY) begin n_fail++; $display("FAIL rb_final: done=%b error=%b expected 1 and %b", done, error, VERIFY); end
    corrupt = 1'b0;
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rb_err_clear: got %b expected 0", error); end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_restart();
    test_backpressure();
    test_start_abort();
    test_readback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/fb_port_a_loader.md
Name: fb_port_a_loader

Overview:
- Writer for port A of the dual-port framebuffer RAM. In the display top level, port B is the read side scanned by the VGA module.
- Accepts a byte stream from an upstream source (CPU store path or serial loader) over a valid/ready handshake.
- Writes the bytes sequentially into the 400x400 8-bit image region, then signals completion.

Parameters:
- ADDR_W, 19, RAM address width (port A matches port B)
- BASE_ADDR, 0, first framebuffer address written
- DEPTH, 160000, bytes per image (400 x 400)
- RD_LAT, 2, port A read latency in cycles, address to q_a (used only with the optional feature)

Ports:
- clk  in  1  system clock; same clock as the RAM
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a load
- abort  in  1  synchronous abort back to IDLE
- in_data  in  8  pixel byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte
- address_a  out  ADDR_W  RAM port A address
- data_a  out  8  RAM port A write data
- wren_a  out  1  RAM port A write enable
- q_a  in  8  RAM port A read data (unused without the optional feature)
- busy  out  1  load in progress
- done  out  1  load complete; held high until the next start
- byte_count  out  ADDR_W  bytes accepted in the current load
- error  out  1  sticky readback mismatch (0 without the optional feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; address_a=BASE_ADDR; data_a=0; wren_a=0; in_ready=0; busy=0; done=0; byte_count=0; error=0.
- States: IDLE, LOAD, DONE (plus VERIFY with the optional feature).
- IDLE:
  - start=1 -> LOAD.
  - byte_count=0, ptr=BASE_ADDR, done=0, error=0, busy=1 from the next cycle.
- LOAD:
  - in_ready=1.
  - Transfer happens on a cycle where in_valid and in_ready are both 1.
  - On a transfer, the next cycle drives address_a=ptr, data_a=in_data, wren_a=1 for exactly that one cycle. Write latency is 1 cycle.
  - ptr and byte_count increment by 1 per transfer.
  - wren_a=0 on every cycle not following a transfer.
  - Transfer with byte_count == DEPTH-1 (the last byte): in_ready=0 from the next cycle; state -> DONE once the final write pulse is issued.
- DONE:
  - busy=0, done=1, in_ready=0.
  - start -> LOAD; done clears.
- start while busy: ignored.
- abort (any state):
  - Next cycle: IDLE, wren_a=0, busy=0, done=0.
  - A write already registered in the same cycle as abort is suppressed.
  - byte_count holds its value for debug.
- in_valid with in_ready=0: not consumed. Upstream must hold the data.
- Address arithmetic: ptr is ADDR_W bits unsigned and never exceeds BASE_ADDR+DEPTH-1. No wrap inside a load. BASE_ADDR+DEPTH must be at most 2^ADDR_W; check this with an elaboration assertion.
- Reset mid-load: immediate IDLE, all outputs at reset values. The partial image stays in RAM.

Optional Feature:
- Macro: FB_READBACK_VERIFY_EN.
- Defined:
  - After each write pulse, enter VERIFY: drive address_a=ptr, wren_a=0, in_ready=0.
  - Wait RD_LAT cycles, then compare q_a with the stored written byte.
  - Mismatch sets error=1 (sticky until the next start) and latches err_addr internally.
  - Then return to LOAD, or to DONE after the last byte.
  - Throughput: one byte per 2+RD_LAT cycles.
- Undefined:
  - No VERIFY state; q_a ignored; error tied to 0.
  - Full throughput of one byte per cycle.

Decomposition:
- Shared package fb_pkg holds:
  - FB_ADDR_W=19
  - FB_IMG_W=400, FB_IMG_H=400, FB_DEPTH=160000
  - FB_QUAD_STEP=100
  - loader_state_t enum {IDLE, LOAD, VERIFY, DONE}
- One natural sub-module: fb_addr_counter (load, increment, terminal-count flag). Everything else stays in the top FSM.

Test Plan:
- Reset then idle: rst_n low for 3 cycles then high, no start -> wren_a=0, in_ready=0, busy=0, done=0 for 20 cycles.
- Full load with DEPTH overridden to 16, BASE_ADDR=0x100: start, then 16 bytes 0x00..0x0F with in_valid held high:
  - Expected: 16 consecutive wren_a pulses at 0x100..0x10F with matching data.
  - done=1 one cycle after the last write; byte_count=16.
- Backpressure and gaps: in_valid toggled at random for the same load -> writes only on transfers, addresses contiguous, no duplicated or dropped byte.
- Start while busy, and abort: start pulsed at byte 5 -> ignored. abort at byte 8 -> IDLE next cycle, no wren_a afterwards, byte_count=8.
- Restart after DONE: second start -> done clears, writes restart at BASE_ADDR.
- FB_READBACK_VERIFY_EN, RD_LAT=2, RAM model corrupting address 0x103:
  - Expected: error=1 after the verify of byte 3; the load still completes with done=1.
  - Inter-byte spacing is 4 cycles.
